// File: rtl/conway_view_scanner.sv
// Snapshots an 8x8 toroidal window of the life grid once per frame and row-scans it to a LED matrix.
// Optional blinking pattern overlay is enabled by defining CURSOR_OVERLAY_EN.
module conway_view_scanner #(
   parameter int unsigned MAX_X     = 32,
   parameter int unsigned MAX_Y     = 32,
   parameter int unsigned ROW_HOLD  = 1000,
   parameter int unsigned BLANK_CYC = 16,
   parameter int unsigned BLINK_FR  = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   scan_en_i,
   input  logic [MAX_X*MAX_Y-1:0] state_i,
   input  logic [7:0]             cursor_x_i,
   input  logic [7:0]             cursor_y_i,
   input  logic [63:0]            pattern_mat_i,
   output logic [7:0]             row_sel_o,
   output logic [7:0]             col_data_o,
   output logic                   frame_done_o,
   output logic                   busy_o
);

   localparam int unsigned Cells = MAX_X * MAX_Y;
   localparam int unsigned IdxW  = $clog2(Cells);
   localparam int unsigned MaxPh = (ROW_HOLD > BLANK_CYC) ? ROW_HOLD : BLANK_CYC;
   localparam int unsigned CntW  = (MaxPh > 1) ? $clog2(MaxPh) : 1;

   typedef enum logic [1:0] {StIdle, StLatch, StBlank, StDrive} state_e;

   state_e          st_q, st_d;
   logic [2:0]      row_q, row_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            stop_q, stop_d;
   logic [7:0]      x0_q, x0_d;
   logic [7:0]      ry_q, ry_d;
   logic [7:0]      fbuf_q [8];
   logic [7:0]      row_sel_q, row_sel_d;
   logic [7:0]      col_q, col_d;
   logic            fd_q, fd_d;
   logic            enter_latch;
   logic            copy_en;
   logic [7:0]      snap_row;
   logic [7:0]      drive_bits;

   // Increment with wrap; operand is always below lim, so one subtraction suffices.
   function automatic logic [7:0] wrap_inc(input logic [7:0] v, input int unsigned lim);
      logic [8:0] n;
      n = {1'b0, v} + 9'd1;
      if (n >= 9'(lim)) n = n - 9'(lim);
      return n[7:0];
   endfunction

   always_comb begin
      logic [7:0]      c;
      logic [IdxW-1:0] idx;
      snap_row = 8'd0;
      c        = x0_q;
      for (int dx = 0; dx < 8; dx++) begin
         idx          = IdxW'({24'd0, ry_q} * MAX_X + {24'd0, c});
         snap_row[dx] = state_i[idx];
         c            = wrap_inc(c, MAX_X);
      end
   end

   always_comb begin
      st_d        = st_q;
      row_d       = row_q;
      cnt_d       = cnt_q;
      stop_d      = stop_q;
      fd_d        = 1'b0;
      x0_d        = x0_q;
      ry_d        = ry_q;
      copy_en     = 1'b0;
      enter_latch = 1'b0;
      unique case (st_q)
         StIdle: begin
            stop_d = 1'b0;
            if (scan_en_i) enter_latch = 1'b1;
         end
         StLatch: begin
            copy_en = 1'b1;
            ry_d    = wrap_inc(ry_q, MAX_Y);
            if (row_q == 3'd7) begin
               st_d  = StBlank;
               row_d = 3'd0;
               cnt_d = '0;
            end else begin
               row_d = row_q + 3'd1;
            end
         end
         StBlank: begin
            stop_d = stop_q | ~scan_en_i;
            if (cnt_q == CntW'(BLANK_CYC - 1)) begin
               cnt_d = '0;
               st_d  = stop_d ? StIdle : StDrive;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDrive: begin
            stop_d = stop_q | ~scan_en_i;
            if (cnt_q == CntW'(ROW_HOLD - 1)) begin
               cnt_d = '0;
               if (row_q == 3'd7) begin
                  fd_d = 1'b1;
                  if (stop_d) st_d = StIdle;
                  else        enter_latch = 1'b1;
               end else if (stop_d) begin
                  st_d = StIdle;
               end else begin
                  st_d  = StBlank;
                  row_d = row_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: st_d = StIdle;
      endcase
      if (enter_latch) begin
         st_d   = StLatch;
         row_d  = 3'd0;
         cnt_d  = '0;
         stop_d = 1'b0;
         x0_d   = (cursor_x_i >= 8'(MAX_X)) ? 8'd0 : cursor_x_i;
         ry_d   = (cursor_y_i >= 8'(MAX_Y)) ? 8'd0 : cursor_y_i;
      end
   end

`ifdef CURSOR_OVERLAY_EN
   localparam int unsigned BlkW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

   logic [BlkW-1:0] blk_cnt_q;
   logic            blink_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         blk_cnt_q <= '0;
         blink_q   <= 1'b0;
      end else if (fd_d) begin
         if (blk_cnt_q == BlkW'(BLINK_FR - 1)) begin
            blk_cnt_q <= '0;
            blink_q   <= ~blink_q;
         end else begin
            blk_cnt_q <= blk_cnt_q + 1'b1;
         end
      end
   end

   assign drive_bits = fbuf_q[row_d] | (blink_q ? pattern_mat_i[{row_d, 3'b000} +: 8] : 8'd0);
`else
   localparam int unsigned UnusedBlinkFr = BLINK_FR;
   logic unused_pattern;
   assign unused_pattern = ^pattern_mat_i;
   assign drive_bits     = fbuf_q[row_d];
`endif

   // Outputs only move when a DRIVE phase starts or ends.
   always_comb begin
      row_sel_d = row_sel_q;
      col_d     = col_q;
      if (st_d != StDrive) begin
         row_sel_d = 8'd0;
         col_d     = 8'd0;
      end else if (st_q != StDrive) begin
         row_sel_d = 8'd1 << row_d;
         col_d     = drive_bits;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q      <= StIdle;
         row_q     <= 3'd0;
         cnt_q     <= '0;
         stop_q    <= 1'b0;
         x0_q      <= 8'd0;
         ry_q      <= 8'd0;
         row_sel_q <= 8'd0;
         col_q     <= 8'd0;
         fd_q      <= 1'b0;
         for (int i = 0; i < 8; i++) fbuf_q[i] <= 8'd0;
      end else begin
         st_q      <= st_d;
         row_q     <= row_d;
         cnt_q     <= cnt_d;
         stop_q    <= stop_d;
         x0_q      <= x0_d;
         ry_q      <= ry_d;
         row_sel_q <= row_sel_d;
         col_q     <= col_d;
         fd_q      <= fd_d;
         if (copy_en) fbuf_q[row_q] <= snap_row;
      end
   end

   assign row_sel_o    = row_sel_q;
   assign col_data_o   = col_q;
   assign frame_done_o = fd_q;
   assign busy_o       = (st_q != StIdle);

endmodule
